// File: rtl/drc_pixel_capture_if.sv
// Signal bundle between the DVP pixel capture stage and its surroundings:
// camera byte bus and qualifiers in, pixel FIFO write side and status out.
interface drc_pixel_capture_if #(
  parameter int CNT_W = 11
) ();
  logic             pclk_sync;
  logic [7:0]       dvp_d_i;
  logic             dvp_href_i;
  logic             dvp_vsync_i;
  logic             fifo_full_i;
  logic [15:0]      pix_data_o;
  logic             pix_wr_o;
  logic             frame_start_o;
  logic             frame_end_o;
  logic             line_end_o;
  logic [CNT_W-1:0] col_cnt_o;
  logic [CNT_W-1:0] row_cnt_o;
  logic             ovf_o;
  logic             line_err_o;

  modport master (
    output pclk_sync, dvp_d_i, dvp_href_i, dvp_vsync_i, fifo_full_i,
    input  pix_data_o, pix_wr_o, frame_start_o, frame_end_o, line_end_o,
           col_cnt_o, row_cnt_o, ovf_o, line_err_o
  );

  modport slave (
    input  pclk_sync, dvp_d_i, dvp_href_i, dvp_vsync_i, fifo_full_i,
    output pix_data_o, pix_wr_o, frame_start_o, frame_end_o, line_end_o,
           col_cnt_o, row_cnt_o, ovf_o, line_err_o
  );
endinterface

// File: rtl/drc_pixel_capture.sv
// DVP byte-to-pixel capture: packs byte pairs into RGB565 pixels on each PCLK
// strobe, tracks frame/line boundaries, counts rows/columns, flags errors.
module drc_pixel_capture #(
  parameter int   DATA_DLY  = 2,
  parameter logic VSYNC_POL = 1'b1,
  parameter logic HI_FIRST  = 1'b1,
  parameter int   CNT_W     = 11
) (
  input logic               clk,
  input logic               rst_n,
  drc_pixel_capture_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FRAME = 2'd1,
    S_LINE  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Delay line entries are packed as {vsync, href, data}.
  logic [9:0] w_stage_in [DATA_DLY];
  logic [9:0] r_stage    [DATA_DLY];

  genvar gi;
  generate
    for (gi = 0; gi < DATA_DLY; gi++) begin : g_dly
      if (gi == 0) begin : g_first
        assign w_stage_in[gi] = {bus.dvp_vsync_i, bus.dvp_href_i, bus.dvp_d_i};
      end else begin : g_rest
        assign w_stage_in[gi] = r_stage[gi-1];
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    for (int i = 0; i < DATA_DLY; i++) begin
      if (!rst_n) r_stage[i] <= '0;
      else        r_stage[i] <= w_stage_in[i];
    end
  end

  logic [7:0]  w_d_q;
  logic        w_href_q;
  logic        w_vs_act;
  logic [15:0] w_pixel;

  state_t           r_state;
  logic             r_vs_prev;
  logic             r_phase;
  logic [7:0]       r_byte0;
  logic [15:0]      r_pix_data;
  logic             r_pix_wr;
  logic             r_frame_start;
  logic             r_frame_end;
  logic             r_line_end;
  logic [CNT_W-1:0] r_col_cnt;
  logic [CNT_W-1:0] r_row_cnt;
  logic             r_ovf;
  logic             r_line_err;

  assign w_d_q    = r_stage[DATA_DLY-1][7:0];
  assign w_href_q = r_stage[DATA_DLY-1][8];
  assign w_vs_act = (r_stage[DATA_DLY-1][9] == VSYNC_POL);
  assign w_pixel  = HI_FIRST ? {r_byte0, w_d_q} : {w_d_q, r_byte0};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_vs_prev     <= 1'b0;
      r_phase       <= 1'b0;
      r_byte0       <= '0;
      r_pix_data    <= '0;
      r_pix_wr      <= 1'b0;
      r_frame_start <= 1'b0;
      r_frame_end   <= 1'b0;
      r_line_end    <= 1'b0;
      r_col_cnt     <= '0;
      r_row_cnt     <= '0;
      r_ovf         <= 1'b0;
      r_line_err    <= 1'b0;
    end else begin
      r_pix_wr      <= 1'b0;
      r_frame_start <= 1'b0;
      r_frame_end   <= 1'b0;
      r_line_end    <= 1'b0;
      if (bus.pclk_sync) begin
        r_vs_prev <= w_vs_act;
        case (r_state)
          S_IDLE: begin
            // Only a sampled active->inactive vsync edge opens a frame.
            if (r_vs_prev && !w_vs_act) begin
              r_state       <= S_FRAME;
              r_frame_start <= 1'b1;
              r_row_cnt     <= '0;
              r_col_cnt     <= '0;
              r_ovf         <= 1'b0;
              r_line_err    <= 1'b0;
              r_phase       <= 1'b0;
            end
          end
          S_FRAME: begin
            if (w_vs_act) begin
              r_frame_end <= 1'b1;
              r_state     <= S_IDLE;
            end else if (w_href_q) begin
              r_state   <= S_LINE;
              r_col_cnt <= '0;
              r_byte0   <= w_d_q;
              r_phase   <= 1'b1;
            end
          end
          S_LINE: begin
            if (w_vs_act || !w_href_q) begin
              r_line_end <= 1'b1;
              if (r_row_cnt != CNT_MAX) r_row_cnt <= r_row_cnt + 1'b1;
              if (r_phase) r_line_err <= 1'b1;
              r_phase <= 1'b0;
              if (w_vs_act) begin
                r_frame_end <= 1'b1;
                r_state     <= S_IDLE;
              end else begin
                r_state <= S_FRAME;
              end
            end else if (!r_phase) begin
              r_byte0 <= w_d_q;
              r_phase <= 1'b1;
            end else begin
              // Dropped pixels still count as columns; there is no retry.
              r_phase <= 1'b0;
              if (r_col_cnt != CNT_MAX) r_col_cnt <= r_col_cnt + 1'b1;
              if (bus.fifo_full_i) begin
                r_ovf <= 1'b1;
              end else begin
                r_pix_wr   <= 1'b1;
                r_pix_data <= w_pixel;
              end
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.pix_data_o    = r_pix_data;
  assign bus.pix_wr_o      = r_pix_wr;
  assign bus.frame_start_o = r_frame_start;
  assign bus.frame_end_o   = r_frame_end;
  assign bus.line_end_o    = r_line_end;
  assign bus.col_cnt_o     = r_col_cnt;
  assign bus.row_cnt_o     = r_row_cnt;
  assign bus.ovf_o         = r_ovf;
  assign bus.line_err_o    = r_line_err;

endmodule

// File: tb/tb_drc_pixel_capture.sv
// Self-checking bench for drc_pixel_capture: directed scenarios with literal
// expectations plus randomized traffic, all compared against a byte-list model.
module tb_drc_pixel_capture;
  localparam int   DLY   = 2;
  localparam logic POL   = 1'b1;
  localparam logic HIF   = 1'b1;
  localparam int   CW    = 3;
  localparam int   MAXC  = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  drc_pixel_capture_if #(.CNT_W(CW)) bus_if ();

  drc_pixel_capture #(
    .DATA_DLY(DLY), .VSYNC_POL(POL), .HI_FIRST(HIF), .CNT_W(CW)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus_if)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit          m_in_frame, m_in_line, m_armed;
  logic [7:0]  m_bytes[$];
  int          m_col, m_row;
  bit          m_ovf, m_lerr, m_wr, m_fs, m_fe, m_le;
  logic [15:0] m_data;
  logic [9:0]  hist[$];

  always @(posedge clk) begin : p_model
    logic [9:0]  s;
    logic [15:0] px;
    bit          va;
    m_wr = 0; m_fs = 0; m_fe = 0; m_le = 0;
    if (!rst_n) begin
      hist = {};
      repeat (DLY) hist.push_back(10'h000);
      m_in_frame = 0; m_in_line = 0; m_armed = 0;
      m_bytes.delete();
      m_col = 0; m_row = 0; m_ovf = 0; m_lerr = 0; m_data = 16'h0000;
    end else begin
      s = hist[$];
      if (bus_if.pclk_sync) begin
        va = (s[9] == POL);
        if (!m_in_frame) begin
          if (m_armed && !va) begin
            m_in_frame = 1; m_fs = 1;
            m_row = 0; m_col = 0; m_ovf = 0; m_lerr = 0;
            m_bytes.delete();
          end
        end else if (!m_in_line) begin
          if (va) begin
            m_fe = 1; m_in_frame = 0;
          end else if (s[8]) begin
            m_in_line = 1; m_col = 0;
            m_bytes = {s[7:0]};
          end
        end else if (va || !s[8]) begin
          m_le = 1;
          m_row = (m_row < MAXC) ? m_row + 1 : MAXC;
          if (m_bytes.size() != 0) m_lerr = 1;
          m_bytes.delete();
          m_in_line = 0;
          if (va) begin
            m_fe = 1; m_in_frame = 0;
          end
        end else begin
          m_bytes.push_back(s[7:0]);
          if (m_bytes.size() == 2) begin
            px = HIF ? {m_bytes[0], m_bytes[1]} : {m_bytes[1], m_bytes[0]};
            m_bytes.delete();
            m_col = (m_col < MAXC) ? m_col + 1 : MAXC;
            if (bus_if.fifo_full_i) m_ovf = 1;
            else begin
              m_wr = 1; m_data = px;
            end
          end
        end
        m_armed = va;
      end
      hist.push_front({bus_if.dvp_vsync_i, bus_if.dvp_href_i, bus_if.dvp_d_i});
      void'(hist.pop_back());
    end
  end

  // ---------------- per-cycle compare and event monitor ----------------
  logic [15:0] wr_log[$];
  int fs_cnt = 0, fe_cnt = 0, le_cnt = 0, le_fe_same = 0;

  function automatic logic [27:0] dut_vec();
    return {bus_if.pix_wr_o, bus_if.pix_data_o, bus_if.frame_start_o,
            bus_if.frame_end_o, bus_if.line_end_o, bus_if.col_cnt_o,
            bus_if.row_cnt_o, bus_if.ovf_o, bus_if.line_err_o};
  endfunction

  always @(posedge clk) begin : p_mon
    logic [27:0] exp_v;
    #2;
    exp_v = {m_wr, m_data, m_fs, m_fe, m_le, m_col[CW-1:0], m_row[CW-1:0], m_ovf, m_lerr};
    chk("cycle_outputs", {4'h0, dut_vec()}, {4'h0, exp_v});
    if (bus_if.pix_wr_o) wr_log.push_back(bus_if.pix_data_o);
    if (bus_if.frame_start_o) fs_cnt++;
    if (bus_if.frame_end_o) fe_cnt++;
    if (bus_if.line_end_o) le_cnt++;
    if (bus_if.line_end_o && bus_if.frame_end_o) le_fe_same++;
  end

  // ---------------- stimulus helpers ----------------
  task automatic drive_pclk(input logic [7:0] d, input logic href, input logic vs_on,
                            input logic full, input int gap);
    @(negedge clk);
    bus_if.dvp_d_i     = d;
    bus_if.dvp_href_i  = href;
    bus_if.dvp_vsync_i = vs_on ? POL : ~POL;
    bus_if.pclk_sync   = 1'b0;
    repeat (DLY + gap) @(negedge clk);
    bus_if.pclk_sync   = 1'b1;
    bus_if.fifo_full_i = full;
    @(negedge clk);
    bus_if.pclk_sync   = 1'b0;
    bus_if.fifo_full_i = 1'b0;
  endtask

  task automatic vsync_pulse();
    repeat (4) drive_pclk(8'h00, 1'b0, 1'b1, 1'b0, 0);
    drive_pclk(8'h00, 1'b0, 1'b0, 1'b0, 0);
  endtask

  task automatic send_line(input logic [7:0] b[$], input int full_pix,
                           input int full_pct, input int gap_max);
    for (int i = 0; i < b.size(); i++) begin
      logic f;
      f = ((i / 2 == full_pix) && (i % 2 == 1)) || (int'($urandom_range(99)) < full_pct);
      drive_pclk(b[i], 1'b1, 1'b0, f, int'($urandom_range(gap_max)));
    end
    drive_pclk(8'h00, 1'b0, 1'b0, 1'b0, int'($urandom_range(gap_max)));
  endtask

  task automatic flush();
    repeat (DLY + 3) @(negedge clk);
  endtask

  // ---------------- main sequence ----------------
  logic [7:0]  lb[$];
  logic [15:0] basic_px [4];
  int n0, l0, f0, s0;

  initial begin
    basic_px[0] = 16'h1234; basic_px[1] = 16'h5678;
    basic_px[2] = 16'h9ABC; basic_px[3] = 16'hDEF0;
    bus_if.pclk_sync = 1'b0; bus_if.dvp_d_i = 8'h00; bus_if.dvp_href_i = 1'b0;
    bus_if.dvp_vsync_i = ~POL; bus_if.fifo_full_i = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_outputs", {4'h0, dut_vec()}, 32'h0);

    // Basic line
    n0 = wr_log.size(); l0 = le_cnt; s0 = fs_cnt;
    vsync_pulse();
    lb = {8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
    send_line(lb, -1, 0, 0);
    flush();
    chk("basic_fs", fs_cnt - s0, 1);
    chk("basic_writes", wr_log.size() - n0, 4);
    for (int k = 0; k < 4; k++) chk("basic_pixel", {16'h0, wr_log[n0+k]}, {16'h0, basic_px[k]});
    chk("basic_line_end", le_cnt - l0, 1);
    chk("basic_col", bus_if.col_cnt_o, 4);
    chk("basic_row", bus_if.row_cnt_o, 1);
    $display("basic line: %0d writes", wr_log.size() - n0);

    // Frame counting
    f0 = fe_cnt;
    for (int ln = 0; ln < 2; ln++) begin
      lb = {};
      for (int k = 0; k < 8; k++) lb.push_back(8'(ln * 16 + k));
      send_line(lb, -1, 0, 1);
    end
    drive_pclk(8'h00, 1'b0, 1'b1, 1'b0, 0);
    flush();
    chk("frame_end_once", fe_cnt - f0, 1);
    chk("frame_rows", bus_if.row_cnt_o, 3);
    chk("frame_writes", wr_log.size() - n0, 12);
    drive_pclk(8'h00, 1'b0, 1'b0, 1'b0, 0);
    flush();
    chk("next_frame_row_clear", bus_if.row_cnt_o, 0);
    $display("frame counting: %0d writes", wr_log.size() - n0);

    // Overflow on 2nd pixel
    n0 = wr_log.size();
    lb = {8'hA1, 8'hA2, 8'hB1, 8'hB2, 8'hC1, 8'hC2, 8'hD1, 8'hD2};
    send_line(lb, 1, 0, 0);
    flush();
    chk("ovf_writes", wr_log.size() - n0, 3);
    chk("ovf_px0", {16'h0, wr_log[n0]},   32'hA1A2);
    chk("ovf_px1", {16'h0, wr_log[n0+1]}, 32'hC1C2);
    chk("ovf_px2", {16'h0, wr_log[n0+2]}, 32'hD1D2);
    chk("ovf_flag", bus_if.ovf_o, 1);
    chk("ovf_col", bus_if.col_cnt_o, 4);
    $display("overflow: %0d writes", wr_log.size() - n0);

    // Odd-length line, then a clean line
    n0 = wr_log.size();
    lb = {8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    send_line(lb, -1, 0, 0);
    flush();
    chk("odd_writes", wr_log.size() - n0, 2);
    chk("odd_line_err", bus_if.line_err_o, 1);
    lb = {8'h66, 8'h77, 8'h88, 8'h99};
    send_line(lb, -1, 0, 0);
    flush();
    chk("odd_next_px0", {16'h0, wr_log[n0+2]}, 32'h6677);
    chk("odd_next_px1", {16'h0, wr_log[n0+3]}, 32'h8899);
    chk("ovf_held", bus_if.ovf_o, 1);
    drive_pclk(8'h00, 1'b0, 1'b1, 1'b0, 0);
    drive_pclk(8'h00, 1'b0, 1'b0, 1'b0, 0);
    flush();
    chk("flags_clear_ovf", bus_if.ovf_o, 0);
    chk("flags_clear_lerr", bus_if.line_err_o, 0);
    $display("odd line: %0d writes", wr_log.size() - n0);

    // Vsync mid-line
    s0 = le_fe_same;
    drive_pclk(8'h01, 1'b1, 1'b0, 1'b0, 0);
    drive_pclk(8'h02, 1'b1, 1'b0, 1'b0, 0);
    drive_pclk(8'h03, 1'b1, 1'b0, 1'b0, 0);
    drive_pclk(8'h04, 1'b1, 1'b1, 1'b0, 0);
    flush();
    chk("midline_le_fe_same", le_fe_same - s0, 1);
    chk("midline_line_err", bus_if.line_err_o, 1);
    n0 = wr_log.size();
    for (int k = 0; k < 6; k++) drive_pclk(8'(k + 8'h40), 1'b1, 1'b1, 1'b0, 0);
    drive_pclk(8'h00, 1'b0, 1'b1, 1'b0, 0);
    flush();
    chk("midline_no_writes", wr_log.size() - n0, 0);
    $display("vsync mid-line: %0d writes after", wr_log.size() - n0);

    // Reset mid-pixel
    vsync_pulse();
    n0 = wr_log.size();
    drive_pclk(8'h5A, 1'b1, 1'b0, 1'b0, 0);
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    flush();
    chk("rst_mid_outputs", {4'h0, dut_vec()}, 32'h0);
    chk("rst_mid_no_write", wr_log.size() - n0, 0);
    lb = {8'h21, 8'h43, 8'h65, 8'h87};
    send_line(lb, -1, 0, 0);
    flush();
    chk("rst_no_capture", wr_log.size() - n0, 0);
    vsync_pulse();
    send_line(lb, -1, 0, 0);
    flush();
    chk("rst_recover_writes", wr_log.size() - n0, 2);
    chk("rst_recover_px0", {16'h0, wr_log[n0]},   32'h2143);
    chk("rst_recover_px1", {16'h0, wr_log[n0+1]}, 32'h6587);
    $display("reset mid-pixel: %0d writes", wr_log.size() - n0);

    // Randomized frames with gaps, FIFO-full and saturation
    for (int f = 0; f < 6; f++) begin
      int nl;
      n0 = wr_log.size();
      vsync_pulse();
      nl = int'($urandom_range(1, 10));
      for (int ln = 0; ln < nl; ln++) begin
        lb = {};
        repeat ($urandom_range(0, 19)) lb.push_back(8'($urandom));
        if ($urandom_range(7) == 0) begin
          foreach (lb[k]) drive_pclk(lb[k], 1'b1, 1'b0, 1'b0, 0);
          drive_pclk(8'h00, 1'b1, 1'b1, 1'b0, 0);
          break;
        end
        send_line(lb, -1, 20, 2);
      end
      drive_pclk(8'h00, 1'b0, 1'b1, 1'b0, 0);
      flush();
      $display("random frame %0d: %0d lines, %0d writes", f, nl, wr_log.size() - n0);
    end

    // Free-running random traffic including back-to-back strobes and resets
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      bus_if.pclk_sync   = ($urandom_range(2) != 0);
      bus_if.dvp_d_i     = 8'($urandom);
      if ($urandom_range(5) == 0)  bus_if.dvp_href_i  = ~bus_if.dvp_href_i;
      if ($urandom_range(39) == 0) bus_if.dvp_vsync_i = ~bus_if.dvp_vsync_i;
      bus_if.fifo_full_i = ($urandom_range(4) == 0);
      rst_n              = ($urandom_range(499) != 0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    bus_if.pclk_sync = 1'b0;
    flush();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
